// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_BITS LSB-first, optional even parity, stop.
// Define UART_TX_PARITY_EN to insert the parity bit (11-bit frame).
`timescale 1ns/1ps
module uart_tx #(
  parameter int DATA_BITS     = 8,
  parameter int TICKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [11:0]          baud_div,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_e;
`endif

  state_e                 state_q;
  logic [11:0]            div_q;
  logic [11:0]            div_d;
  logic [11:0]            cnt_q;
  logic [11:0]            cnt_d;
  logic [TW-1:0]          tnum_q;
  logic [TW-1:0]          tnum_d;
  logic [BW-1:0]          bidx_q;
  logic [DATA_BITS-1:0]   sh_q;
`ifdef UART_TX_PARITY_EN
  logic                   par_q;
`endif
  logic                   txd_q;
  logic                   ready_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   tick;
  logic                   bit_end;
  logic                   pre_end;

  assign div_d   = (baud_div < 12'd2) ? 12'd2 : baud_div;
  assign tick    = (cnt_q == div_q - 12'd1);
  assign bit_end = tick && (tnum_q == TLAST);
  // one cycle ahead of bit_end, so tx_done can stay a plain register
  assign pre_end = (cnt_q == div_q - 12'd2) && (tnum_q == TLAST);

  always_comb begin
    cnt_d  = tick ? 12'd0 : cnt_q + 12'd1;
    tnum_d = tnum_q;
    if (tick) begin
      tnum_d = (tnum_q == TLAST) ? '0 : tnum_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= 12'd2;
      cnt_q   <= '0;
      tnum_q  <= '0;
      bidx_q  <= '0;
      sh_q    <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
      txd_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) begin
        cnt_q  <= cnt_d;
        tnum_q <= tnum_d;
      end
      unique case (state_q)
        IDLE: begin
          if (tx_valid && ready_q) begin
            state_q <= START;
            div_q   <= div_d;
            cnt_q   <= '0;
            tnum_q  <= '0;
            bidx_q  <= '0;
            sh_q    <= tx_data;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^tx_data;
`endif
            txd_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            txd_q   <= sh_q[0];
            sh_q    <= sh_q >> 1;
            bidx_q  <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bidx_q == BLAST) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              txd_q   <= par_q;
`else
              state_q <= STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              bidx_q <= bidx_q + BW'(1);
              txd_q  <= sh_q[0];
              sh_q   <= sh_q >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            txd_q   <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (pre_end) begin
            done_q <= 1'b1;
          end
          if (bit_end) begin
            state_q <= IDLE;
            txd_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign txd      = txd_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized scoreboard bench for uart_tx; frames are predicted from
// the line protocol (bit list x bit length) and compared cycle by cycle.
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int DB  = 8;
  localparam int TPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = DB + 3;
`else
  localparam int NBITS = DB + 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [11:0]   baud_div;
  logic [DB-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          txd;
  logic          tx_busy;
  logic          tx_done;

  uart_tx #(.DATA_BITS(DB), .TICKS_PER_BIT(TPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .baud_div (baud_div),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .txd      (txd),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DB-1:0] data;
    int            len;
    bit            abort;
  } frame_t;

  frame_t sbq[$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit mon_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int eff_len(input logic [11:0] d);
    return TPB * ((d < 12'd2) ? 2 : int'(d));
  endfunction

  // line level of bit position b in a frame
  function automatic logic exp_level(input frame_t f, input int b);
    if (b == 0) return 1'b0;
    if (b <= DB) return f.data[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == DB + 1) return ^f.data;
`endif
    return 1'b1;
  endfunction

  initial begin : mon
    frame_t f;
    int n, errs, done_at, ndone;
    bit ab;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || txd !== 1'b0) continue;
      if (sbq.size() == 0) begin
        chk("unexpected_start", 1, 0);
        for (int i = 0; i < 60000 && txd !== 1'b1; i++) @(negedge clk);
        continue;
      end
      f = sbq.pop_front();
      mon_busy = 1'b1;
      n = NBITS * f.len;
      errs = 0; done_at = -1; ndone = 0; ab = 1'b0;
      for (int c = 1; c <= n; c++) begin
        if (c > 1) @(negedge clk);
        if (rst) begin ab = 1'b1; break; end
        if (txd !== exp_level(f, (c - 1) / f.len)) errs++;
        if (tx_ready !== 1'b0 || tx_busy !== 1'b1) errs++;
        if (tx_done === 1'b1) begin ndone++; done_at = c; end
        else if (tx_done !== 1'b0) errs++;
      end
      chk("abort_seen", 32'(ab), 32'(f.abort));
      if (ab) begin
        chk("abort_prefix_errs", errs, 0);
        chk("abort_no_done", ndone, 0);
      end else begin
        chk("frame_wave_errs", errs, 0);
        chk("done_count", ndone, 1);
        chk("done_cycle", done_at, n);
        @(negedge clk);
        chk("idle_gap", {txd, tx_ready, tx_busy, tx_done}, 4'b1100);
      end
      mon_busy = 1'b0;
    end
  end

  // called and returns at #1 after a rising edge
  task automatic send(input logic [DB-1:0] d, input logic [11:0] div,
                      input bit hold, input bit ab);
    frame_t f;
    int w;
    tx_data = d; baud_div = div; tx_valid = 1'b1; w = 0;
    while (tx_ready !== 1'b1 && w < 60000) begin
      @(posedge clk); #1; w++;
    end
    if (tx_ready !== 1'b1) begin
      chk("accept_timeout", 0, 1);
      tx_valid = 1'b0;
      return;
    end
    f.data = d; f.len = eff_len(div); f.abort = ab;
    sbq.push_back(f);
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while ((sbq.size() != 0 || mon_busy) && w < 60000) begin
      @(posedge clk); #1; w++;
    end
    if (sbq.size() != 0 || mon_busy) chk("drain_timeout", 0, 1);
  endtask

  initial begin : drv
    int first, nd;
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; baud_div = 12'd2;
    repeat (3) @(posedge clk);
    #1;
    tx_valid = 1'b1; tx_data = 8'h3C;
    @(posedge clk); #1;
    rst = 1'b0; tx_valid = 1'b0;
    chk("reset_state", {txd, tx_ready, tx_busy, tx_done}, 4'b1100);
    @(posedge clk); #1;
    chk("rst_priority", {tx_busy, txd}, 2'b01);

    send(8'hA5, 12'd2, 1'b0, 1'b0); wait_done();
    send(8'hA5, 12'd0, 1'b0, 1'b0); wait_done();
    send(8'h5A, 12'd1, 1'b0, 1'b0); wait_done();

    send(8'h55, 12'd4, 1'b1, 1'b0);
    first = acc_cyc;
    send(8'hAA, 12'd4, 1'b0, 1'b0);
    chk("b2b_gap", acc_cyc - first, NBITS * 16 + 1);
    wait_done();

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(DB'($urandom), 12'($urandom_range(0, 5)), 1'b0, 1'b0);
      wait_done();
    end

    send(8'hC3, 12'd2, 1'b0, 1'b1);
    repeat (36) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_state", {txd, tx_ready, tx_busy, tx_done}, 4'b1100);
    nd = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_done !== 1'b0) nd++;
    end
    chk("abort_no_late_done", nd, 0);
    @(posedge clk); #1;
    wait_done();
    send(8'h81, 12'd3, 1'b0, 1'b0); wait_done();

`ifdef UART_TX_PARITY_EN
    send(8'h07, 12'd2, 1'b0, 1'b0); wait_done();
`endif

    send(8'h00, 12'd1302, 1'b0, 1'b0);
    repeat (99) @(posedge clk);
    #1;
    baud_div = 12'd4;
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #(95000 * 10);
    $display("FAIL watchdog: run still active, expected completion");
    $fatal(1);
  end

endmodule
